// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter slice: prescaler width,
// direction encoding and the terminal-count helper.
package counter_pkg;

    localparam int unsigned PRESCALE_W = 16;
    localparam logic        DIR_UP     = 1'b1;
    localparam logic        DIR_DOWN   = 1'b0;

    // Callers truncate the result to their own WIDTH.
    function automatic logic [31:0] max_count(input int unsigned modulo);
        return 32'(modulo - 1);
    endfunction

endpackage

// File: rtl/prescaled_counter_tick_gen.sv
// Clock-enable prescaler: registered one-cycle tick every PRESCALE enabled
// clk cycles; clr restarts the period and suppresses the tick.
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_div_cnt;
    logic                  r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (clr) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (en) begin
            if (r_div_cnt == LAST) begin
                r_div_cnt <= '0;
                r_tick    <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + PRESCALE_W'(1);
                r_tick    <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/prescaled_counter.sv
// Modulo-N up/down counter with clamped synchronous load, advanced by a
// single-domain prescaler tick. Define PRESCALED_COUNTER_SATURATE_EN to
// saturate at the limits instead of wrapping (wrap then flags overflow).
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 16,
    parameter int unsigned MODULO   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULO));

`ifdef PRESCALED_COUNTER_SATURATE_EN
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = MAX_Q;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = '0;
`else
    localparam logic [WIDTH-1:0] UP_LIMIT_NEXT   = '0;
    localparam logic [WIDTH-1:0] DOWN_LIMIT_NEXT = MAX_Q;
`endif

    logic             w_tick;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (w_tick)
    );

    always_comb begin
        w_load_q = load_val;
        if (load_val > MAX_Q) w_load_q = MAX_Q;
    end

    // Load wins over a tick registered on the same edge; that tick is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_q;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            if (up_dn == DIR_UP) begin
                if (r_q == MAX_Q) begin
                    r_q    <= UP_LIMIT_NEXT;
                    r_wrap <= 1'b1;
                end else begin
                    r_q    <= r_q + WIDTH'(1);
                    r_wrap <= 1'b0;
                end
            end else begin
                if (r_q == '0) begin
                    r_q    <= DOWN_LIMIT_NEXT;
                    r_wrap <= 1'b1;
                end else begin
                    r_q    <= r_q - WIDTH'(1);
                    r_wrap <= 1'b0;
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tick = w_tick;
    assign wrap = r_wrap;

endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
Parametrised successor to the team's divide-and-count pair. The prescaler is a clock-enable tick generator, not a derived clock, so the whole block sits in the single `clk` domain. A modulo-N up/down counter with synchronous load advances on each tick. Used for LED/display sequencing and slow timebases on the board; drops in wherever the old ripple-clocked counter chain was used.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 16, `clk` cycles per tick; legal range 1..65535.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; gates the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- q  out  WIDTH  counter value.
- tick  out  1  registered one-cycle prescaler strobe.
- wrap  out  1  registered one-cycle strobe on modulo wrap.

Behaviour:
- Reset (`rst`=1, async): prescaler count `div_cnt`=0, `q`=0, `tick`=0, `wrap`=0. Release is synchronous to `clk` at the point of use; no glitch on outputs.
- Prescaler:
  - `div_cnt` is a 16-bit register; the width is fixed.
  - On an edge with `en`=1 and `div_cnt`=PRESCALE-1: `div_cnt` goes to 0 and `tick` goes to 1.
  - On an edge with `en`=1 otherwise: `div_cnt` increments and `tick` goes to 0.
  - On an edge with `en`=0: `div_cnt` holds and `tick` goes to 0.
  - PRESCALE=1: `tick`=1 on every enabled cycle.
- Counter:
  - `q` changes only on an edge where registered `tick`=1, or on load.
  - Latency from reset release with `en` held high: first `tick` after PRESCALE edges, first `q` change after PRESCALE+1 edges.
- Up count: if `q`=MODULO-1, then `q` goes to 0 and `wrap` goes to 1; else `q` goes to `q`+1.
- Down count: if `q`=0, then `q` goes to MODULO-1 and `wrap` goes to 1; else `q` goes to `q`-1.
- `wrap` is a one-cycle pulse, 0 on all other edges.
- Load, which has priority over counting:
  - `load`=1 sets `q` to `load_val`. If `load_val` > MODULO-1, `q` is clamped to MODULO-1.
  - Load also clears `div_cnt` to 0 and forces `tick` and `wrap` to 0 on that edge.
  - A tick pending on the same edge is discarded.
- `up_dn` is sampled on the tick edge; changing it mid-period is legal and takes effect on the next tick.
- `en`=0 with `load`=1: the load still occurs.
- Reset asserted mid-period: all state returns to reset values immediately; the prescaler phase is lost.
- Arithmetic is unsigned WIDTH-bit; MODULO-1 is compared explicitly, never relying on natural overflow unless MODULO=2**WIDTH.

Optional Feature:
- Macro PRESCALED_COUNTER_SATURATE_EN.
- Defined: counter saturates. Up at MODULO-1 holds, down at 0 holds, and `wrap` pulses once on the tick that attempts to pass the limit (acts as an overflow flag).
- Not defined: modulo wrap as above.

Decomposition:
- Package `counter_pkg`: `PRESCALE_W`=16, the direction constants `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0, and a function computing MODULO-1 as a WIDTH-bit value.
- Natural sub-module: `tick_gen` (prescaler: `clk`, `rst`, `en`, `clr`, `tick`, parameter PRESCALE), instantiated once. The top level holds the counter and load logic.

Test Plan:
All cases use WIDTH=4, PRESCALE=4, MODULO=10 unless noted.
- Reset then `en`=1, `up_dn`=1 → `tick` at edges 4, 8, 12…; `q`=1 after edge 5, `q`=2 after edge 9.
- Count up from `q`=9 → on next tick `q`=0 with `wrap`=1 for exactly one cycle; with SATURATE_EN, `q` stays 9 and `wrap`=1.
- `up_dn`=0 from `q`=0 → `q`=9 and `wrap`=1; then 8, 7 on following ticks.
- `load`=1, `load_val`=4'd13 on the same edge as a `tick` → `q`=9 (clamped), `tick`=0, `div_cnt`=0; next tick arrives 4 enabled edges later.
- `en` toggled low for 3 cycles at `div_cnt`=2 → no tick during the gap; tick arrives 2 enabled edges after `en` returns.
- `rst` pulsed for 1 ns mid-period between clock edges → `q`=0, `tick`=0, `wrap`=0 immediately; PRESCALE=1 build counts every enabled cycle.
